// File: rtl/rrat_freelist.sv
// Retirement RAT plus physical-register free list. Commits update the
// architectural map and recycle displaced tags; rename pops tags speculatively.
module rrat_freelist #(
    parameter int NUM_ARCH = 32,
    parameter int NUM_PHYS = 64,
    parameter int PTAG_W   = 6,
    parameter int FL_DEPTH = NUM_PHYS - NUM_ARCH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       stall,
    input  logic                       flush,
    input  logic                       alloc_req,
    output logic                       alloc_valid,
    output logic [PTAG_W-1:0]          alloc_preg,
    input  logic                       newMap_flag_rrat,
    input  logic [$clog2(NUM_ARCH)-1:0] reg2map_rrat,
    input  logic [PTAG_W-1:0]          newMap_rrat,
    output logic [NUM_ARCH*PTAG_W-1:0] rrat_map,
    output logic [PTAG_W-1:0]          free_count,
    output logic                       commit_order_err
);

    localparam int IDX_W = $clog2(FL_DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [PTAG_W-1:0] map_q [NUM_ARCH];
    logic [PTAG_W-1:0] fl_q  [FL_DEPTH];

    logic [PTR_W-1:0] spec_head_q, spec_head_d;
    logic [PTR_W-1:0] ret_head_q,  ret_head_d;
    logic [PTR_W-1:0] tail_q,      tail_d;
    logic             err_q,       err_d;

    logic              commit_act;
    logic              alloc_fire;
    logic [PTR_W-1:0]  count;
    logic [PTAG_W-1:0] old_tag;

    assign count       = tail_q - spec_head_q;
    assign alloc_valid = (count != '0);
    assign alloc_preg  = fl_q[spec_head_q[IDX_W-1:0]];
    assign free_count  = PTAG_W'(count);

    assign commit_act  = newMap_flag_rrat && (reg2map_rrat != '0);
    assign alloc_fire  = alloc_req && alloc_valid && !stall && !flush;
    assign old_tag     = map_q[reg2map_rrat];

    assign commit_order_err = err_q;

    for (genvar gi = 0; gi < NUM_ARCH; gi++) begin : g_map_out
        assign rrat_map[gi*PTAG_W +: PTAG_W] = map_q[gi];
    end

    always_comb begin
        ret_head_d  = ret_head_q;
        tail_d      = tail_q;
        err_d       = err_q;
        spec_head_d = spec_head_q;
        if (commit_act) begin
            ret_head_d = ret_head_q + PTR_W'(1);
            tail_d     = tail_q + PTR_W'(1);
            if (newMap_rrat != fl_q[ret_head_q[IDX_W-1:0]]) begin
                err_d = 1'b1;
            end
        end
        // Flush rewinds to the committed head, after any same-cycle commit.
        if (flush) begin
            spec_head_d = ret_head_d;
        end else if (alloc_fire) begin
            spec_head_d = spec_head_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_ARCH; i++) begin
                map_q[i] <= PTAG_W'(i);
            end
            for (int k = 0; k < FL_DEPTH; k++) begin
                fl_q[k] <= PTAG_W'(NUM_ARCH + k);
            end
            spec_head_q <= '0;
            ret_head_q  <= '0;
            // Index 0 with the wrap bit set: the list starts full.
            tail_q      <= PTR_W'(FL_DEPTH);
            err_q       <= 1'b0;
        end else begin
            if (commit_act) begin
                map_q[reg2map_rrat]        <= newMap_rrat;
                fl_q[tail_q[IDX_W-1:0]]    <= old_tag;
            end
            spec_head_q <= spec_head_d;
            ret_head_q  <= ret_head_d;
            tail_q      <= tail_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_rrat_freelist.sv
// Directed bench for rrat_freelist: reset, allocation, commit recycling,
// drain/refill, flush rollback, order-error flag and stalls.
module tb_rrat_freelist;

    logic         clk = 1'b0;
    logic         reset;
    logic         stall;
    logic         flush;
    logic         alloc_req;
    logic         alloc_valid;
    logic [5:0]   alloc_preg;
    logic         newMap_flag_rrat;
    logic [4:0]   reg2map_rrat;
    logic [5:0]   newMap_rrat;
    logic [191:0] rrat_map;
    logic [5:0]   free_count;
    logic         commit_order_err;

    int vectors     = 0;
    int miscompares = 0;
    logic [5:0] emap [32];

    rrat_freelist dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .flush            (flush),
        .alloc_req        (alloc_req),
        .alloc_valid      (alloc_valid),
        .alloc_preg       (alloc_preg),
        .newMap_flag_rrat (newMap_flag_rrat),
        .reg2map_rrat     (reg2map_rrat),
        .newMap_rrat      (newMap_rrat),
        .rrat_map         (rrat_map),
        .free_count       (free_count),
        .commit_order_err (commit_order_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [191:0] packed_emap();
        logic [191:0] v;
        for (int i = 0; i < 32; i++) v[i*6 +: 6] = emap[i];
        return v;
    endfunction

    task automatic emap_reset();
        for (int i = 0; i < 32; i++) emap[i] = 6'(i);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        emap_reset();
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_map"},   rrat_map, packed_emap());
        chk({tag, "_preg"},  192'(alloc_preg), 192'(32));
        chk({tag, "_valid"}, 192'(alloc_valid), 192'(1));
        chk({tag, "_count"}, 192'(free_count), 192'(32));
        chk({tag, "_err"},   192'(commit_order_err), 192'(0));
    endtask

    // n single-cycle allocations; each tag checked before it is consumed
    task automatic alloc_n(input int n, input int first);
        for (int i = 0; i < n; i++) begin
            chk("alloc_tag", 192'(alloc_preg), 192'((first + i) % 64));
            alloc_req = 1'b1;
            tick();
            alloc_req = 1'b0;
        end
    endtask

    task automatic commit(input logic [4:0] r, input logic [5:0] t);
        newMap_flag_rrat = 1'b1;
        reg2map_rrat     = r;
        newMap_rrat      = t;
        tick();
        newMap_flag_rrat = 1'b0;
        reg2map_rrat     = '0;
        newMap_rrat      = '0;
        if (r != 0) emap[r] = t;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0; alloc_req = 1'b0;
        newMap_flag_rrat = 1'b0; reg2map_rrat = '0; newMap_rrat = '0;
        emap_reset();

        // 1: reset state
        do_reset();
        chk_reset_state("s1");

        // 2: allocate, commit, recycle across wrap
        alloc_n(3, 32);
        chk("s2_count29", 192'(free_count), 192'(29));
        commit(5'd5, 6'd32);
        chk("s2_map5", 192'(rrat_map[35:30]), 192'(32));
        chk("s2_count30", 192'(free_count), 192'(30));
        alloc_n(29, 35);
        chk("s2_recycled", 192'(alloc_preg), 192'(5));
        chk("s2_count1", 192'(free_count), 192'(1));
        chk("s2_err", 192'(commit_order_err), 192'(0));

        // 3: drain, ignored request, same-cycle commit refills
        do_reset();
        alloc_n(32, 32);
        chk("s3_empty", 192'(alloc_valid), 192'(0));
        chk("s3_count0", 192'(free_count), 192'(0));
        alloc_req = 1'b1;
        tick();
        chk("s3_ignored", 192'(free_count), 192'(0));
        newMap_flag_rrat = 1'b1; reg2map_rrat = 5'd7; newMap_rrat = 6'd32;
        chk("s3_valid_same", 192'(alloc_valid), 192'(0));
        tick();
        alloc_req = 1'b0; newMap_flag_rrat = 1'b0; reg2map_rrat = '0; newMap_rrat = '0;
        emap[7] = 6'd32;
        chk("s3_valid_next", 192'(alloc_valid), 192'(1));
        chk("s3_preg7", 192'(alloc_preg), 192'(7));
        chk("s3_count1", 192'(free_count), 192'(1));
        chk("s3_map", rrat_map, packed_emap());

        // 4: flush together with commit
        do_reset();
        alloc_n(4, 32);
        chk("s4_count28", 192'(free_count), 192'(28));
        flush = 1'b1; alloc_req = 1'b1;
        commit(5'd3, 6'd32);
        flush = 1'b0; alloc_req = 1'b0;
        chk("s4_map3", 192'(rrat_map[23:18]), 192'(32));
        chk("s4_count32", 192'(free_count), 192'(32));
        alloc_n(1, 33);
        chk("s4_count31", 192'(free_count), 192'(31));

        // 5: reg-0 commit is a no-op; out-of-order commit sets sticky error
        do_reset();
        commit(5'd0, 6'd32);
        chk_reset_state("s5_r0");
        alloc_n(1, 32);
        commit(5'd4, 6'd40);
        chk("s5_err_set", 192'(commit_order_err), 192'(1));
        chk("s5_map", rrat_map, packed_emap());
        chk("s5_count", 192'(free_count), 192'(32));
        tick();
        tick();
        chk("s5_err_held", 192'(commit_order_err), 192'(1));

        // 6: stall blocks allocation; reset mid-sequence
        do_reset();
        stall = 1'b1; alloc_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("s6_stall_count", 192'(free_count), 192'(32));
            chk("s6_stall_preg", 192'(alloc_preg), 192'(32));
        end
        stall = 1'b0; alloc_req = 1'b0;
        alloc_n(10, 32);
        for (int i = 0; i < 4; i++) commit(5'(i + 1), 6'(32 + i));
        chk("s6_count26", 192'(free_count), 192'(26));
        chk("s6_map", rrat_map, packed_emap());
        chk("s6_err", 192'(commit_order_err), 192'(0));
        alloc_req = 1'b1;
        do_reset();
        alloc_req = 1'b0;
        chk_reset_state("s6_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
